code_programmer: RTL
====================

Name: code_programmer

Overview:
- Writer side of the alarm's code check: lets the user program a new button code, which the sequence detector then compares entries against.
- Takes debounced buttons b1/b2/b3 and check, plus the low-frequency tick from the frequency divider.
- The user enters the new code twice (entry, then confirmation). If both entries match, the block commits the code to a held output register.
- Active only while the top level holds prog_req high (alarm disarmed).

Parameters:
- CODE_LEN, 4, number of digits in the code.
- DEFAULT_CODE, 8'b01_11_10_01, code value loaded at reset (2 bits per digit; digit 0 in bits [1:0], i.e. sequence 1,2,3,1).
- TIMEOUT_TICKS, 50, number of tick_lf pulses without activity before an entry is aborted with an error.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- prog_req  input  1  level; programming permitted while high
- b1  input  1  debounced button 1 (level)
- b2  input  1  debounced button 2 (level)
- b3  input  1  debounced button 3 (level)
- check  input  1  debounced confirm button (level)
- tick_lf  input  1  one-cycle low-frequency tick
- code  output  2*CODE_LEN  committed code, digit i at bits [2i+1:2i]
- prog_active  output  1  high while in ENTER1 or ENTER2
- prog_done  output  1  one-cycle pulse on successful commit
- prog_err  output  1  one-cycle pulse on failed entry

Behaviour:
- Reset (async, rst=1):
  - code=DEFAULT_CODE.
  - FSM=IDLE; prog_active=0, prog_done=0, prog_err=0.
  - Digit index, timeout counter, shadow registers and edge-detect registers all cleared.
  - Reset mid-entry discards the shadow contents; code returns to DEFAULT_CODE.
- Edge detection:
  - Each of b1, b2, b3, check and prog_req is registered once.
  - An event is the input high while its registered copy is low.
  - The FSM acts on the same clock edge that first samples the input high.
  - Holding a button gives exactly one event.
- Digit encoding: b1 -> 2'd1, b2 -> 2'd2, b3 -> 2'd3. Value 2'd0 never appears in a valid code.
- IDLE:
  - A prog_req rising event moves to ENTER1 with idx=0 and the timeout counter cleared.
  - All other events are ignored.
- ENTER1:
  - A single button event writes its digit to shadow1[idx]; idx increments and the timeout counter clears.
  - A check event with idx==CODE_LEN moves to ENTER2, with idx=0 and the timeout counter cleared.
- ENTER2:
  - Same entry rules as ENTER1, writing into shadow2.
  - A check event with idx==CODE_LEN and shadow2==shadow1 commits: code<=shadow1, prog_done=1 for the next cycle, FSM -> IDLE.
- Error conditions (ENTER1/ENTER2 only). Each sends the FSM to IDLE with prog_err=1 for one cycle and code unchanged:
  - two or more button events in the same cycle;
  - a button event and a check event in the same cycle;
  - a button event when idx==CODE_LEN;
  - a check event when idx!=CODE_LEN;
  - confirmation mismatch;
  - the timeout counter reaching TIMEOUT_TICKS (counts tick_lf while in ENTER states).
- Abort: prog_req low while in ENTER1/ENTER2 sends the FSM to IDLE silently (no prog_err, no prog_done). This takes priority over any event in the same cycle.
- Re-entry: a new session requires a fresh prog_req rising edge. Holding prog_req high after done or error does not restart.
- prog_done and prog_err are never high in the same cycle.
- code is stable at all times except on the commit edge.

Test Plan:
- Reset release -> code=8'b01_11_10_01; prog_active=0, prog_done=0, prog_err=0.
- prog_req rise; enter 2,2,3,1 then check; enter 2,2,3,1 then check -> prog_done pulses 1 cycle; code=8'b01_11_10_10; prog_active falls.
- Same flow but confirmation 2,2,3,3 -> prog_err 1 cycle; code unchanged at DEFAULT_CODE.
- Check after 3 digits; separately, 5th digit before check -> prog_err pulse each time, FSM IDLE; b1 and b2 rising in the same cycle -> prog_err.
- Start entry, send 50 tick_lf with no buttons -> prog_err on the 50th tick; send 49 ticks then a button -> no error, counter restarts.
- Drop prog_req mid-ENTER2 -> IDLE, no pulses; assert rst mid-entry after a prior commit -> code=DEFAULT_CODE immediately, asynchronously.

Source files
------------

// File: rtl/code_programmer.sv
// code_programmer: writer side of the alarm code check. Captures a new button code
// twice (entry, then confirmation) and commits it to a held register when both agree.
`timescale 1ns/1ps
module code_programmer #(
   parameter int                    CODE_LEN      = 4,
   parameter logic [2*CODE_LEN-1:0] DEFAULT_CODE  = 8'b01_11_10_01,
   parameter int                    TIMEOUT_TICKS = 50
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  prog_req,
   input  logic                  b1,
   input  logic                  b2,
   input  logic                  b3,
   input  logic                  check,
   input  logic                  tick_lf,
   output logic [2*CODE_LEN-1:0] code,
   output logic                  prog_active,
   output logic                  prog_done,
   output logic                  prog_err
);

   localparam int CNT_W = $clog2(CODE_LEN + 1);
   localparam int SEL_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
   localparam int TMO_W = $clog2(TIMEOUT_TICKS + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ENTER1 = 2'd1,
      S_ENTER2 = 2'd2
   } state_t;

   state_t                      r_state;
   logic [CNT_W-1:0]            r_idx;
   logic [TMO_W-1:0]            r_tmo;
   logic [CODE_LEN-1:0][1:0]    r_shadow1;
   logic [CODE_LEN-1:0][1:0]    r_shadow2;
   logic [2*CODE_LEN-1:0]       r_code;
   logic                        r_active;
   logic                        r_done;
   logic                        r_err;
   logic                        r_b1_q, r_b2_q, r_b3_q, r_check_q, r_req_q;

   logic                        w_ev_b1, w_ev_b2, w_ev_b3, w_ev_check, w_ev_req;
   logic [1:0]                  w_n_btn;
   logic [1:0]                  w_digit;
   logic                        w_idx_full;
   logic                        w_tmo_last;
   logic                        w_evt_err;
   logic [SEL_W-1:0]            w_sel;

   assign w_ev_b1    = b1       & ~r_b1_q;
   assign w_ev_b2    = b2       & ~r_b2_q;
   assign w_ev_b3    = b3       & ~r_b3_q;
   assign w_ev_check = check    & ~r_check_q;
   assign w_ev_req   = prog_req & ~r_req_q;

   assign w_n_btn    = {1'b0, w_ev_b1} + {1'b0, w_ev_b2} + {1'b0, w_ev_b3};
   assign w_idx_full = (r_idx == CNT_W'(CODE_LEN));
   assign w_tmo_last = (r_tmo == TMO_W'(TIMEOUT_TICKS - 1));
   assign w_sel      = r_idx[SEL_W-1:0];

   // Any event combination that cannot be a legal step of the entry aborts it.
   assign w_evt_err  = (w_n_btn > 2'd1)
                     || ((w_n_btn == 2'd1) && (w_ev_check || w_idx_full))
                     || (w_ev_check && !w_idx_full);

   // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
   always_comb begin
      w_digit = 2'd3;
      if (w_ev_b1)      w_digit = 2'd1;
      else if (w_ev_b2) w_digit = 2'd2;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_b1_q    <= 1'b0;
         r_b2_q    <= 1'b0;
         r_b3_q    <= 1'b0;
         r_check_q <= 1'b0;
         r_req_q   <= 1'b0;
      end else begin
         r_b1_q    <= b1;
         r_b2_q    <= b2;
         r_b3_q    <= b3;
         r_check_q <= check;
         r_req_q   <= prog_req;
      end
   end

   // NOTE: non-blocking assignments so every register samples the pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_idx     <= '0;
         r_tmo     <= '0;
         // NOTE: the shadow registers are small flops, not RAM, so they take the reset too.
         r_shadow1 <= '0;
         r_shadow2 <= '0;
         r_code    <= DEFAULT_CODE;
         r_active  <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_ev_req) begin
                  r_state  <= S_ENTER1;
                  r_active <= 1'b1;
                  r_idx    <= '0;
                  r_tmo    <= '0;
               end
            end
            S_ENTER1, S_ENTER2: begin
               if (!prog_req) begin
                  r_state  <= S_IDLE;
                  r_active <= 1'b0;
               end else if (w_evt_err) begin
                  r_state  <= S_IDLE;
                  r_active <= 1'b0;
                  r_err    <= 1'b1;
               end else if (w_n_btn == 2'd1) begin
                  if (r_state == S_ENTER1) r_shadow1[w_sel] <= w_digit;
                  else                     r_shadow2[w_sel] <= w_digit;
                  r_idx <= r_idx + CNT_W'(1);
                  r_tmo <= '0;
               end else if (w_ev_check) begin
                  if (r_state == S_ENTER1) begin
                     r_state <= S_ENTER2;
                     r_idx   <= '0;
                     r_tmo   <= '0;
                  end else begin
                     r_state  <= S_IDLE;
                     r_active <= 1'b0;
                     if (r_shadow2 == r_shadow1) begin
                        r_code <= r_shadow1;
                        r_done <= 1'b1;
                     end else begin
                        r_err  <= 1'b1;
                     end
                  end
               end else if (tick_lf) begin
                  if (w_tmo_last) begin
                     r_state  <= S_IDLE;
                     r_active <= 1'b0;
                     r_err    <= 1'b1;
                  end else begin
                     r_tmo <= r_tmo + TMO_W'(1);
                  end
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_active <= 1'b0;
            end
         endcase
      end
   end

   assign code        = r_code;
   assign prog_active = r_active;
   assign prog_done   = r_done;
   assign prog_err    = r_err;

endmodule
